fan_sync_ctrl: RTL

Closed-loop column scheduler for the LED fan. It measures the revolution period from the hall/index sensor and divides it into `COLS` equal column slots. It drives the per-column strobe and column index consumed by the display modes (word, clock, showoff, setting). It arbitrates the column divisor between the keyboard-tuned manual value and the measured value, falling back to manual whenever lock is lost.

---
 rtl/fan_sync_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fan_sync_ctrl.sv
// fan_sync_ctrl: hall-index locked column scheduler for the LED fan.
// Measures the revolution period, derives the column divisor, emits column strobes.
module fan_sync_ctrl #(
   parameter int unsigned      COLS         = 360,
   parameter int unsigned      CNT_W        = 27,
   parameter logic [CNT_W-1:0] DEFAULT_FREQ = CNT_W'(21600),
   parameter logic [CNT_W-1:0] MIN_PER      = CNT_W'(1000),
   parameter logic [CNT_W-1:0] TIMEOUT      = CNT_W'(100_000_000)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             index,
   input  logic             mode_auto,
   input  logic [CNT_W-1:0] manual_freq,
   output logic [CNT_W-1:0] freq,
   output logic             col_tick,
   output logic [8:0]       col_idx,
   output logic             rev_start,
   output logic             locked
);

   localparam logic [1:0]       S_UNL  = 2'd0;
   localparam logic [1:0]       S_ACQ  = 2'd1;
   localparam logic [1:0]       S_TRK  = 2'd2;
   localparam int unsigned      BC_W   = $clog2(CNT_W + 1);
   localparam logic [9:0]       L_COLS = 10'(COLS);
   localparam logic [8:0]       L_LAST = 9'(COLS - 1);
   localparam logic [CNT_W-1:0] L_ONES = '1;
   localparam logic [CNT_W-1:0] L_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] L_TWO  = CNT_W'(2);

   logic [2:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_state;
   logic             r_pv;
   logic [CNT_W-1:0] r_pprev;
   logic [8:0]       r_rem;
   logic [CNT_W-1:0] r_quo;
   logic [BC_W-1:0]  r_bcnt;
   logic             r_busy;
   logic [CNT_W-1:0] r_auto;
   logic [CNT_W-1:0] r_freq;
   logic [CNT_W-1:0] r_cc;
   logic [8:0]       r_idx;

   logic             w_edge;
   logic             w_acc;
   logic             w_tmo;
   logic             w_start;
   logic [CNT_W-1:0] w_diff;
   logic             w_match;
   logic [9:0]       w_sh;
   logic             w_ge;
   logic [8:0]       w_rnx;
   logic [CNT_W-1:0] w_qnx;
   logic             w_realign;
   logic [CNT_W-1:0] w_cc_cur;
   logic [8:0]       w_idx_cur;
   logic [CNT_W:0]   w_cc_p1;
   logic             w_last;
   logic [8:0]       w_idx_inc;

   // r_sync[1:0] is the metastability pair, r_sync[2] the edge-detect delay
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[1:0], index};
   end

   assign w_edge = r_sync[1] & ~r_sync[2];
   assign w_acc  = w_edge && (r_cnt >= MIN_PER);
   assign w_tmo  = (r_cnt == TIMEOUT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_cnt <= '0;
      else if (w_acc)          r_cnt <= L_ONE;
      else if (r_cnt != L_ONES) r_cnt <= r_cnt + L_ONE;
   end

   assign w_diff  = (r_cnt >= r_pprev) ? r_cnt - r_pprev : r_pprev - r_cnt;
   assign w_match = r_pv && (w_diff <= (r_pprev >> 3));
   assign w_start = w_acc && !w_tmo && (r_state != S_UNL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_UNL;
         r_pv    <= 1'b0;
         r_pprev <= '0;
      end else if (w_tmo) begin
         r_state <= S_UNL;
         r_pv    <= 1'b0;
      end else if (w_acc) begin
         if (r_state == S_UNL) begin
            r_state <= S_ACQ;
         end else begin
            r_state <= w_match ? S_TRK : S_ACQ;
            r_pprev <= r_cnt;
            r_pv    <= 1'b1;
         end
      end
   end

   assign locked    = (r_state == S_TRK);
   assign rev_start = w_acc;

   // restoring divide by COLS: remainder always < COLS so 9 bits suffice
   assign w_sh  = {r_rem, r_quo[CNT_W-1]};
   assign w_ge  = (w_sh >= L_COLS);
   assign w_rnx = w_ge ? 9'(w_sh - L_COLS) : w_sh[8:0];
   assign w_qnx = {r_quo[CNT_W-2:0], w_ge};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rem  <= '0;
         r_quo  <= '0;
         r_bcnt <= '0;
         r_busy <= 1'b0;
         r_auto <= DEFAULT_FREQ;
      end else if (w_start) begin
         r_rem  <= '0;
         r_quo  <= r_cnt;
         r_bcnt <= BC_W'(CNT_W);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_rem  <= w_rnx;
         r_quo  <= w_qnx;
         r_bcnt <= r_bcnt - BC_W'(1);
         if (r_bcnt == BC_W'(1)) begin
            r_busy <= 1'b0;
            r_auto <= (w_qnx < L_TWO) ? L_TWO : w_qnx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     r_freq <= DEFAULT_FREQ;
      else if (mode_auto && locked) r_freq <= r_auto;
      else                          r_freq <= manual_freq;
   end

   assign freq = r_freq;

   // a realign makes this cycle behave as column 0, slot 0
   assign w_realign = w_acc && locked;
   assign w_cc_cur  = w_realign ? '0 : r_cc;
   assign w_idx_cur = w_realign ? '0 : r_idx;
   assign w_cc_p1   = {1'b0, w_cc_cur} + (CNT_W+1)'(1);
   assign w_last    = (w_cc_p1 >= {1'b0, r_freq});
   assign w_idx_inc = (w_idx_cur != L_LAST) ? w_idx_cur + 9'd1 :
                      (locked ? L_LAST : 9'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cc  <= '0;
         r_idx <= '0;
      end else if (w_last) begin
         r_cc  <= '0;
         r_idx <= w_idx_inc;
      end else begin
         r_cc  <= w_cc_p1[CNT_W-1:0];
         r_idx <= w_idx_cur;
      end
   end

   assign col_tick = (w_cc_cur == '0);
   assign col_idx  = w_idx_cur;

endmodule
